// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
//
// Purpose:
//   Two-lane traffic-light sequencer. In automatic mode it runs a timed cycle.
//   In manual mode lane switches request which lane gets green. Every green
//   leaves through yellow and then an all-red clearance. Durations are counted
//   in prescaler `tick` pulses, not in clocks.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   tick                one-clk-wide timing enable for all durations
//   auto_mode           1 = automatic timed cycle, 0 = manual (sw1/sw2)
//   sw1, sw2            manual requests for lane A / lane B green
//   laneA_red/yellow/green, laneB_red/yellow/green
//                       registered lamp drives, exactly one lit per lane
//   phase[2:0]          registered state code (CLR=0 A_GRN=1 A_YEL=2
//                       B_GRN=3 B_YEL=4) for debug LEDs
// -----------------------------------------------------------------------------
module traffic_phase_controller #(
   parameter int GREEN_T   = 30,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int MIN_GREEN = 5,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       auto_mode,
   input  logic       sw1,
   input  logic       sw2,
   output logic       laneA_red,
   output logic       laneA_yellow,
   output logic       laneA_green,
   output logic       laneB_red,
   output logic       laneB_yellow,
   output logic       laneB_green,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      CLR   = 3'd0,
      A_GRN = 3'd1,
      A_YEL = 3'd2,
      B_GRN = 3'd3,
      B_YEL = 3'd4
   } phaseE;

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } laneE;

   typedef enum logic [1:0] {
      TGT_NONE = 2'd0,
      TGT_A    = 2'd1,
      TGT_B    = 2'd2
   } targetE;

   typedef struct packed {
      logic aRed;
      logic aYel;
      logic aGrn;
      logic bRed;
      logic bYel;
      logic bGrn;
   } lampsT;

   // "Last tick" thresholds: a state entered with cnt=0 expires on its T-th tick.
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_FULL = CNT_W'(ALLRED_T);
   localparam logic [CNT_W-1:0] MIN_GRN     = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   phaseE            state, stateNxt;
   laneE             nextLane, nextLaneNxt;
   logic [CNT_W-1:0] cnt, cntNxt;
   lampsT            lamps, lampsNxt;
   targetE           target;

   logic greenExp, yellowExp, clrExp, clrDone, minGreenMet;

   assign greenExp    = tick && (cnt >= GREEN_LAST);
   assign yellowExp   = tick && (cnt >= YELLOW_LAST);
   assign clrExp      = tick && (cnt >= ALLRED_LAST);
   // Once clearance has run its full length the counter keeps showing it
   // (saturation), so a manual request arriving later leaves without a tick.
   assign clrDone     = clrExp || (cnt >= ALLRED_FULL);
   assign minGreenMet = (cnt >= MIN_GRN);

   // State register: state, counter, lane memory and lamp drives.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state    <= CLR;
         nextLane <= LANE_A;
         cnt      <= '0;
         lamps    <= '{aRed: 1'b1, aYel: 1'b0, aGrn: 1'b0,
                       bRed: 1'b1, bYel: 1'b0, bGrn: 1'b0};
      end else begin
         state    <= stateNxt;
         nextLane <= nextLaneNxt;
         cnt      <= cntNxt;
         lamps    <= lampsNxt;
      end
   end

   // Next-state logic. Transitions look at the pre-update counter; the counter
   // then clears on any state change, so an exit tick never carries over.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      target      = TGT_NONE;
      stateNxt    = state;
      nextLaneNxt = nextLane;
      cntNxt      = cnt;

      if (sw1 && !sw2) begin
         target = TGT_A;
      end else if (sw2 && !sw1) begin
         target = TGT_B;
      end

      case (state)
         CLR: begin
            if (auto_mode) begin
               if (clrExp) begin
                  stateNxt = (nextLane == LANE_A) ? A_GRN : B_GRN;
               end
            end else if (clrDone) begin
               if (target == TGT_A) begin
                  stateNxt = A_GRN;
               end else if (target == TGT_B) begin
                  stateNxt = B_GRN;
               end
            end
         end
         A_GRN: begin
            // Manual release needs no tick: it is checked every clock.
            if (auto_mode ? greenExp : ((target != TGT_A) && minGreenMet)) begin
               stateNxt = A_YEL;
            end
         end
         A_YEL: begin
            if (yellowExp) begin
               stateNxt    = CLR;
               nextLaneNxt = LANE_B;
            end
         end
         B_GRN: begin
            if (auto_mode ? greenExp : ((target != TGT_B) && minGreenMet)) begin
               stateNxt = B_YEL;
            end
         end
         B_YEL: begin
            if (yellowExp) begin
               stateNxt    = CLR;
               nextLaneNxt = LANE_A;
            end
         end
         default: begin
            // Unreachable encodings fall back to the safe all-red state.
            stateNxt = CLR;
         end
      endcase

      if (stateNxt != state) begin
         cntNxt = '0;
      end else if (tick && (cnt != CNT_MAX)) begin
         cntNxt = cnt + CNT_W'(1);
      end
   end

   // Output decode of the next state, so the registered lamps change on the
   // same edge as the state register.
   always_comb begin
      lampsNxt = '{aRed: 1'b1, aYel: 1'b0, aGrn: 1'b0,
                   bRed: 1'b1, bYel: 1'b0, bGrn: 1'b0};
      case (stateNxt)
         A_GRN: begin
            lampsNxt.aRed = 1'b0;
            lampsNxt.aGrn = 1'b1;
         end
         A_YEL: begin
            lampsNxt.aRed = 1'b0;
            lampsNxt.aYel = 1'b1;
         end
         B_GRN: begin
            lampsNxt.bRed = 1'b0;
            lampsNxt.bGrn = 1'b1;
         end
         B_YEL: begin
            lampsNxt.bRed = 1'b0;
            lampsNxt.bYel = 1'b1;
         end
         default: begin
            lampsNxt = '{aRed: 1'b1, aYel: 1'b0, aGrn: 1'b0,
                         bRed: 1'b1, bYel: 1'b0, bGrn: 1'b0};
         end
      endcase
   end

   assign laneA_red    = lamps.aRed;
   assign laneA_yellow = lamps.aYel;
   assign laneA_green  = lamps.aGrn;
   assign laneB_red    = lamps.bRed;
   assign laneB_yellow = lamps.bYel;
   assign laneB_green  = lamps.bGrn;
   assign phase        = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_controller
//
// Directed bench for traffic_phase_controller with short timing parameters
// (GREEN_T=5, YELLOW_T=2, ALLRED_T=1, MIN_GREEN=3). Inputs are driven 1 ns
// after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_traffic_phase_controller;

   localparam int GREEN_T   = 5;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int MIN_GREEN = 3;
   localparam int CNT_W     = 8;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       tick      = 1'b0;
   logic       auto_mode = 1'b1;
   logic       sw1       = 1'b0;
   logic       sw2       = 1'b0;
   logic       laneA_red, laneA_yellow, laneA_green;
   logic       laneB_red, laneB_yellow, laneB_green;
   logic [2:0] phase;
   logic [5:0] lampsObs;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   traffic_phase_controller #(
      .GREEN_T  (GREEN_T),
      .YELLOW_T (YELLOW_T),
      .ALLRED_T (ALLRED_T),
      .MIN_GREEN(MIN_GREEN),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .auto_mode   (auto_mode),
      .sw1         (sw1),
      .sw2         (sw2),
      .laneA_red   (laneA_red),
      .laneA_yellow(laneA_yellow),
      .laneA_green (laneA_green),
      .laneB_red   (laneB_red),
      .laneB_yellow(laneB_yellow),
      .laneB_green (laneB_green),
      .phase       (phase)
   );

   assign lampsObs = {laneA_red, laneA_yellow, laneA_green,
                      laneB_red, laneB_yellow, laneB_green};

   // Lamp pattern {A red,yel,grn, B red,yel,grn} each phase code must show.
   function automatic logic [5:0] lampTable(input logic [2:0] ph);
      case (ph)
         3'd0:    return 6'b100_100;
         3'd1:    return 6'b001_100;
         3'd2:    return 6'b010_100;
         3'd3:    return 6'b100_001;
         3'd4:    return 6'b100_010;
         default: return 6'b000_000;
      endcase
   endfunction

   // Safety rules: consistent lamps, one lamp per lane, the other lane red
   // whenever a lane is not red, green only to yellow, yellow only to CLR.
   function automatic logic isLegal(input logic [2:0] prev, input logic [2:0] ph,
                                    input logic [5:0] l);
      logic ok;
      ok = (ph <= 3'd4) && (l == lampTable(ph));
      ok = ok && ($countones(l[5:3]) == 1) && ($countones(l[2:0]) == 1);
      ok = ok && !(l[0] && l[3]) && (l[5] || l[2]);
      if (prev != ph) begin
         if (prev == 3'd1) ok = ok && (ph == 3'd2);
         if (prev == 3'd3) ok = ok && (ph == 3'd4);
         if (prev == 3'd2 || prev == 3'd4) ok = ok && (ph == 3'd0);
      end
      return ok;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkPhase(input string tag, input logic [2:0] expPhase);
      check(tag, 32'({phase, lampsObs}), 32'({expPhase, lampTable(expPhase)}));
   endtask

   task automatic clkStep(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   // One tick period: tick high for the first clock, low for three.
   task automatic tickPeriods(input int n);
      for (int i = 0; i < n; i++) begin
         clkStep(1'b1);
         repeat (3) clkStep(1'b0);
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (3) clkStep(1'b0);
   endtask

   logic [2:0] autoSeq [17];
   logic [2:0] prevPhase;

   initial begin
      autoSeq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0,
                  3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd1};

      // Reset and the automatic cycle.
      auto_mode = 1'b1;
      doReset();
      checkPhase("reset", 3'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tickPeriods(1);
         checkPhase($sformatf("auto_p%0d", k + 1), autoSeq[k]);
      end

      // Manual hold for 50 ticks, then saturation: 256 ticks after entry the
      // counter must read its maximum, not a wrapped zero.
      doReset();
      auto_mode = 1'b0;
      sw1 = 1'b1;
      sw2 = 1'b0;
      rst_n = 1'b1;
      tickPeriods(1);
      checkPhase("man_enter_a", 3'd1);
      for (int k = 0; k < 50; k++) begin
         tickPeriods(1);
         checkPhase($sformatf("man_hold_%0d", k), 3'd1);
      end
      repeat (206) clkStep(1'b1);
      checkPhase("man_hold_256", 3'd1);
      sw1 = 1'b0;
      sw2 = 1'b1;
      clkStep(1'b0);
      checkPhase("man_sat_release", 3'd2);

      // Manual switch request at cnt=1 waits for MIN_GREEN, then sequences.
      doReset();
      auto_mode = 1'b0;
      sw1 = 1'b1;
      sw2 = 1'b0;
      rst_n = 1'b1;
      tickPeriods(2);
      checkPhase("sw_cnt1", 3'd1);
      sw1 = 1'b0;
      sw2 = 1'b1;
      clkStep(1'b1);
      checkPhase("sw_cnt2", 3'd1);
      repeat (3) clkStep(1'b0);
      checkPhase("sw_cnt2_idle", 3'd1);
      clkStep(1'b1);
      checkPhase("sw_cnt3", 3'd1);
      clkStep(1'b0);
      checkPhase("sw_yel", 3'd2);
      repeat (2) clkStep(1'b0);
      tickPeriods(1);
      checkPhase("sw_yel_t1", 3'd2);
      clkStep(1'b1);
      checkPhase("sw_clr", 3'd0);
      repeat (3) clkStep(1'b0);
      clkStep(1'b1);
      checkPhase("sw_b_grn", 3'd3);

      // Conflicting requests hold all-red; a valid request then exits at once.
      doReset();
      auto_mode = 1'b0;
      sw1 = 1'b1;
      sw2 = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tickPeriods(1);
         checkPhase($sformatf("conflict_%0d", k), 3'd0);
      end
      sw1 = 1'b0;
      clkStep(1'b0);
      checkPhase("conflict_exit", 3'd3);

      // Mode change in B_GRN without resetting the counter.
      auto_mode = 1'b1;
      tickPeriods(2);
      checkPhase("mode_auto_cnt2", 3'd3);
      auto_mode = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tickPeriods(1);
         checkPhase($sformatf("mode_man_cnt%0d", k + 3), 3'd3);
      end
      auto_mode = 1'b1;
      clkStep(1'b0);
      checkPhase("mode_auto_no_tick", 3'd3);
      clkStep(1'b1);
      checkPhase("mode_auto_tick", 3'd4);

      // Reset in the middle of A_YEL, and in CLR while lane B is next.
      auto_mode = 1'b1;
      sw1 = 1'b0;
      sw2 = 1'b0;
      doReset();
      rst_n = 1'b1;
      tickPeriods(6);
      checkPhase("mid_a_yel", 3'd2);
      rst_n = 1'b0;
      clkStep(1'b0);
      checkPhase("mid_reset", 3'd0);
      rst_n = 1'b1;
      tickPeriods(1);
      checkPhase("mid_restart_a", 3'd1);
      tickPeriods(7);
      checkPhase("mid_clr_next_b", 3'd0);
      rst_n = 1'b0;
      clkStep(1'b0);
      checkPhase("clr_reset", 3'd0);
      rst_n = 1'b1;
      tickPeriods(1);
      checkPhase("clr_reset_lane_a", 3'd1);

      // Random soak of switches, mode and tick, checking safety every clock.
      doReset();
      rst_n = 1'b1;
      prevPhase = 3'd0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 15) == 0) auto_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)  sw1       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)  sw2       = 1'($urandom_range(0, 1));
         clkStep(1'($urandom_range(0, 2) == 0));
         check($sformatf("safety_%0d", i), 32'(isLegal(prevPhase, phase, lampsObs)), 32'd1);
         prevPhase = phase;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequenced two-lane traffic-light controller: timed automatic cycle plus a switch-driven manual override.
- Every green-to-other transition passes through yellow, then an all-red clearance. A lane is never switched straight from green to red, or from one lane's green to the other's.
- Sits between the lane switches / mode switch and the lamp drivers, replacing a purely combinational manual decode.
- Timing is counted in `tick` pulses from the shared prescaler, not in raw clocks.

Parameters:
- GREEN_T, 30, auto-mode green duration in ticks (≥1)
- YELLOW_T, 3, yellow duration in ticks (≥1)
- ALLRED_T, 2, all-red clearance duration in ticks (≥1)
- MIN_GREEN, 5, minimum green in manual mode before a requested change is honoured, in ticks (≥1, ≤GREEN_T)
- CNT_W, 8, tick-counter width; must hold max(GREEN_T, YELLOW_T, ALLRED_T)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-clk-wide timing enable; all durations count these
- auto_mode  in  1  1 = automatic timed cycle, 0 = manual
- sw1  in  1  manual request, lane A green
- sw2  in  1  manual request, lane B green
- laneA_red / laneA_yellow / laneA_green  out  1 each  lane A lamps, registered
- laneB_red / laneB_yellow / laneB_green  out  1 each  lane B lamps, registered
- phase  out  3  current state encoding, registered (debug/LED)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=CLR, next_lane=A, cnt=0.
  - Lamps: both reds=1, all yellows/greens=0; phase=CLR.
  - Reset mid-cycle aborts immediately to this condition, regardless of inputs.
- States and phase codes:
  - CLR=0: all red
  - A_GRN=1: A green, B red
  - A_YEL=2: A yellow, B red
  - B_GRN=3: B green, A red
  - B_YEL=4: B yellow, A red
- Exactly one lamp per lane is lit in every state. Both greens, or green+yellow across lanes, is illegal.
- Manual target: A if sw1=1 & sw2=0; B if sw2=1 & sw1=0; NONE otherwise (both on or both off).
- Counter:
  - cnt clears to 0 on every state entry.
  - cnt increments on tick while in a state and saturates at its maximum.
  - "Expires(T)" means tick=1 and cnt ≥ T-1, so a state lasts exactly T ticks if entered fresh.
- Transitions in auto mode (auto_mode=1):
  - A_GRN → A_YEL on expires(GREEN_T); A_YEL → CLR on expires(YELLOW_T) and sets next_lane=B.
  - CLR → (next_lane==A ? A_GRN : B_GRN) on expires(ALLRED_T).
  - B side is symmetric and sets next_lane=A.
- Transitions in manual mode (auto_mode=0):
  - A_GRN → A_YEL when target≠A and cnt ≥ MIN_GREEN, evaluated every clk, no tick needed. Otherwise A_GRN holds indefinitely.
  - A_YEL → CLR on expires(YELLOW_T). Yellow is never aborted.
  - CLR exits only after expires(ALLRED_T):
    - target A → A_GRN;
    - target B → B_GRN;
    - NONE → stay in CLR. cnt saturates, so a later valid request exits on the next clk.
  - B side is symmetric.
- Mode changes take effect at the next clk edge without resetting cnt:
  - manual→auto while in A_GRN with cnt ≥ GREEN_T-1 → A_YEL on the next tick;
  - auto→manual while in A_GRN with target=A → hold green.
- Lamps and phase are registered: they change on the same edge as state. No combinational path from inputs to lamps.
- Simultaneous events: transition conditions are evaluated before the counter update. A tick on the exit edge does not carry into the new state (cnt=0).

Test Plan:
- Reset:
  - GREEN_T=5, YELLOW_T=2, ALLRED_T=1, tick every 4 clk, auto_mode=1; hold rst_n=0 for 3 clk.
  - → lamps A/B red=1, phase=0.
  - After release → CLR 1 tick, A_GRN 5 ticks, A_YEL 2, CLR 1, B_GRN 5, B_YEL 2, CLR 1, A_GRN.
- Manual switch:
  - auto_mode=0, MIN_GREEN=3, sw1=1 → A_GRN held for 50 ticks.
  - sw1=0, sw2=1 at cnt=1 → stays A_GRN until cnt=3, then A_YEL 2 ticks, CLR 1 tick, B_GRN.
- Conflict:
  - auto_mode=0, sw1=sw2=1 from CLR → phase stays 0 for 20 ticks.
  - Drop sw1 → B_GRN on the next clk.
- Mode change:
  - Auto, in B_GRN at cnt=2; set auto_mode=0 with sw2=1 → B_GRN held.
  - Set auto_mode=1 at cnt=7 → B_YEL on the next tick.
- Safety:
  - Random sw1/sw2/auto_mode/tick for 10k clk → never both greens, never any lane green/yellow adjacent to the other lane non-red, yellow always followed by CLR.
- Mid-run reset:
  - Assert rst_n=0 during A_YEL → next clk phase=0, both red, next_lane=A.
